// File: rtl/avl_arb_pkg.sv
// Shared types and constants for the two-requester Avalon-MM bus arbiter.
// Optional round-robin arbitration is selected with the ARB_ROUND_ROBIN_EN macro.
package avl_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_I    = 2'b01;
   localparam logic [1:0] GRANT_D    = 2'b10;

   localparam logic [3:0] FULL_BE    = 4'hF;

endpackage

// File: rtl/avl_arb_select.sv
// Combinational winner picker for the bus arbiter: fixed priority by default,
// pointer-based round-robin when ARB_ROUND_ROBIN_EN is defined.
module avl_arb_select
   import avl_arb_pkg::*;
#(
   parameter int DATA_PRIORITY = 1
) (
   input  logic       i_pend,
   input  logic       d_pend,
`ifdef ARB_ROUND_ROBIN_EN
   input  logic       rr_ptr,
`endif
   output logic [1:0] win
);

   // A lone pending requester always wins; ties go to the pointer or the fixed priority.
   always_comb begin
      win = GRANT_NONE;
      if (i_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
         win = rr_ptr ? GRANT_D : GRANT_I;
`else
         win = (DATA_PRIORITY != 0) ? GRANT_D : GRANT_I;
`endif
      end else if (d_pend) begin
         win = GRANT_D;
      end else if (i_pend) begin
         win = GRANT_I;
      end else begin
         win = GRANT_NONE;
      end
   end

endmodule

// File: rtl/avl_bus_arbiter_chk.sv
// Simulation checker for the arbiter's data requester: flags a request that
// asserts read and write together (the arbiter performs the write only).
module avl_bus_arbiter_chk (
   input  logic clk,
   input  logic reset,
   input  logic d_read,
   input  logic d_write
);

   logic [15:0] conflict_count;

   // Count and report every cycle the data requester presents read and write together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conflict_count <= 16'd0;
      end else if (d_read && d_write) begin
         conflict_count <= conflict_count + 16'd1;
         $warning("avl_bus_arbiter: d_read and d_write both high, read ignored");
      end
   end

endmodule

// File: rtl/avl_bus_arbiter.sv
// Two-requester Avalon-MM arbiter: instruction fetch and data access share one
// registered master port. Define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
module avl_bus_arbiter
   import avl_arb_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int DATA_PRIORITY = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_read,
   input  logic [ADDR_W-1:0]   i_address,
   output logic [DATA_W-1:0]   i_readdata,
   output logic                i_waitrequest,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_address,
   input  logic [DATA_W/8-1:0] d_byteenable,
   input  logic [DATA_W-1:0]   d_writedata,
   output logic [DATA_W-1:0]   d_readdata,
   output logic                d_waitrequest,
   output logic [ADDR_W-1:0]   address,
   output logic                read,
   output logic                write,
   output logic [DATA_W/8-1:0] byteenable,
   output logic [DATA_W-1:0]   writedata,
   input  logic [DATA_W-1:0]   readdata,
   input  logic                waitrequest,
   output logic [1:0]          grant
);

   localparam int BE_W = DATA_W / 8;

   state_t     state;
   state_t     state_next;
   logic [1:0] win;
   logic       load;
   logic       done;
   logic       i_done;
   logic       d_done;

`ifdef ARB_ROUND_ROBIN_EN
   logic       rr_ptr;
`endif

   avl_arb_select #(
      .DATA_PRIORITY (DATA_PRIORITY)
   ) u_select (
      .i_pend (i_read),
      .d_pend (d_read | d_write),
`ifdef ARB_ROUND_ROBIN_EN
      .rr_ptr (rr_ptr),
`endif
      .win    (win)
   );

   // Next-state logic: grant on any pending request, release on a non-stalled bus cycle.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (win != GRANT_NONE) begin
               load       = 1'b1;
               state_next = BUSY;
            end else begin
               state_next = IDLE;
            end
         end
         BUSY: begin
            if (!waitrequest) begin
               done       = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = BUSY;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Master registers: loaded once per grant, held through waitrequest, command cleared on completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant      <= GRANT_NONE;
         address    <= '0;
         read       <= 1'b0;
         write      <= 1'b0;
         byteenable <= '0;
         writedata  <= '0;
      end else if (load) begin
         grant <= win;
         if (win == GRANT_D) begin
            address    <= d_address;
            byteenable <= d_byteenable;
            writedata  <= d_writedata;
            write      <= d_write;
            read       <= d_read & ~d_write;
         end else begin
            address    <= i_address;
            byteenable <= {BE_W{1'b1}};
            writedata  <= '0;
            write      <= 1'b0;
            read       <= 1'b1;
         end
      end else if (done) begin
         grant <= GRANT_NONE;
         read  <= 1'b0;
         write <= 1'b0;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Pointer favours the requester that did not own the bus last.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= 1'b1;
      end else if (done) begin
         rr_ptr <= (grant == GRANT_I);
      end
   end
`endif

   assign i_done        = (state == BUSY) && (grant == GRANT_I) && !waitrequest;
   assign d_done        = (state == BUSY) && (grant == GRANT_D) && !waitrequest;
   assign i_waitrequest = !i_done;
   assign d_waitrequest = !d_done;
   assign i_readdata    = i_done ? readdata : '0;
   assign d_readdata    = d_done ? readdata : '0;

   avl_bus_arbiter_chk u_chk (
      .clk     (clk),
      .reset   (reset),
      .d_read  (d_read),
      .d_write (d_write)
   );

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// Self-checking bench for avl_bus_arbiter: vector table plus hand sequences,
// bus completions checked against a queue of expected transfers.
module tb_avl_bus_arbiter;
   import avl_arb_pkg::*;

   localparam int DP = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_read;
   logic [31:0] i_address;
   logic [31:0] i_readdata;
   logic        i_waitrequest;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_address;
   logic [3:0]  d_byteenable;
   logic [31:0] d_writedata;
   logic [31:0] d_readdata;
   logic        d_waitrequest;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;
   logic [1:0]  grant;

   always #5 clk = ~clk;

   avl_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(DP)) dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_byteenable(d_byteenable),
      .d_writedata(d_writedata), .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
      .address(address), .read(read), .write(write), .byteenable(byteenable),
      .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest), .grant(grant)
   );

   // Slave memory: five known words, programmable wait states per transfer.
   logic [31:0] mem [8];
   logic [3:0]  stall;
   logic [3:0]  mem_wait;
   logic        preload;

   function automatic int midx(input logic [31:0] a);
      case (a)
         32'hBFC00000: return 0;
         32'hBFC00004: return 1;
         32'h00001000: return 2;
         32'h00002000: return 3;
         32'h00003000: return 4;
         default:      return 7;
      endcase
   endfunction

   always_comb readdata    = read ? mem[midx(address)] : 32'h0;
   always_comb waitrequest = (read || write) && (stall < mem_wait);

   always @(posedge clk or posedge reset) begin
      if (reset)                stall <= 4'd0;
      else if (read || write)   stall <= waitrequest ? stall + 4'd1 : 4'd0;
   end

   always @(posedge clk) begin
      if (preload) begin
         mem[0] <= 32'h24020005; mem[1] <= 32'h3C011234; mem[2] <= 32'h00000000;
         mem[3] <= 32'hAAAAAAAA; mem[4] <= 32'h00000000; mem[5] <= 32'h0;
         mem[6] <= 32'h0;        mem[7] <= 32'h0;
      end else if (!reset && write && !waitrequest) begin
         for (int k = 0; k < 4; k++)
            if (byteenable[k]) mem[midx(address)][8*k +: 8] <= writedata[8*k +: 8];
      end
   end

   typedef struct {
      logic [1:0]  g;
      logic [31:0] a;
      logic        rd;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] exp_ir;
      logic [31:0] exp_dr;
   } vec_t;

   exp_t q[$];
   exp_t mon_e;
   vec_t vt[6];
   int   n_vec = 0;
   int   n_err = 0;
   logic m_ptr = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   function automatic logic [1:0] pick(input bit pi, input bit pd);
      if (pi && pd) begin
`ifdef ARB_ROUND_ROBIN_EN
         return m_ptr ? GRANT_D : GRANT_I;
`else
         return (DP != 0) ? GRANT_D : GRANT_I;
`endif
      end else if (pd) begin
         return GRANT_D;
      end else begin
         return GRANT_I;
      end
   endfunction

   // Push the expected completions in arbitration order for the given request mix.
   task automatic push_exp(input vec_t v);
      bit pi = v.ir;
      bit pd = v.dr | v.dw;
      logic [1:0] g;
      exp_t e;
      while (pi || pd) begin
         g = pick(pi, pd);
         if (g == GRANT_D) begin
            e = '{GRANT_D, v.da, v.dr & ~v.dw, v.dw, v.be, v.wd, v.exp_dr};
            pd = 1'b0;
            m_ptr = 1'b0;
         end else begin
            e = '{GRANT_I, v.ia, 1'b1, 1'b0, FULL_BE, 32'h0, v.exp_ir};
            pi = 1'b0;
            m_ptr = 1'b1;
         end
         q.push_back(e);
      end
   endtask

   // Caller is at a negedge; returns the number of cycles until every request completed.
   task automatic drive(input vec_t v, output int cyc);
      i_read = v.ir; i_address = v.ia;
      d_read = v.dr; d_write = v.dw; d_address = v.da; d_byteenable = v.be; d_writedata = v.wd;
      push_exp(v);
      cyc = 0;
      while ((i_read || d_read || d_write) && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (i_read && !i_waitrequest) i_read = 1'b0;
         if ((d_read || d_write) && !d_waitrequest) begin d_read = 1'b0; d_write = 1'b0; end
      end
      if (i_read || d_read || d_write) begin
         chk("drive_timeout", {29'h0, i_read, d_read, d_write}, 32'h0);
         i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
         q.delete();
      end
      @(negedge clk);
      chk("idle_after", {28'h0, read, write, grant}, 32'h0);
   endtask

   // Scoreboard: every non-stalled bus cycle must match the next expected transfer.
   always @(negedge clk) begin
      if (!reset && (read || write) && !waitrequest) begin
         if (q.size() == 0) begin
            chk("unexpected_xfer", address, 32'hFFFFFFFF);
         end else begin
            mon_e = q.pop_front();
            chk("grant", {30'h0, grant}, {30'h0, mon_e.g});
            chk("address", address, mon_e.a);
            chk("cmd", {30'h0, read, write}, {30'h0, mon_e.rd, mon_e.wr});
            chk("byteenable", {28'h0, byteenable}, {28'h0, mon_e.be});
            if (mon_e.wr) chk("writedata", writedata, mon_e.wd);
            if (mon_e.g == GRANT_I) begin
               chk("i_readdata", i_readdata, mon_e.rdata);
               chk("stalls_i", {30'h0, i_waitrequest, d_waitrequest}, 32'h1);
            end else begin
               chk("d_readdata", d_readdata, mon_e.rdata);
               chk("stalls_d", {30'h0, i_waitrequest, d_waitrequest}, 32'h2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int stalls;
      int busy;
      int n;
      logic [1:0] gseq [4];
      logic [1:0] want_seq [4];
      vec_t v;

      vt[0] = '{1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        32'h24020005, 32'h0};
      vt[1] = '{1'b1, 32'hBFC00004, 1'b0, 1'b1, 32'h00001000, 4'hF, 32'hDEADBEEF, 32'h3C011234, 32'h0};
      vt[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h00001000, 4'hF, 32'h0,        32'h0,        32'hDEADBEEF};
      vt[3] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h00002000, 4'h3, 32'h12345678, 32'h0,        32'h0};
      vt[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h00002000, 4'hC, 32'h0,        32'h0,        32'hAAAA5678};
      vt[5] = '{1'b1, 32'hBFC00000, 1'b1, 1'b0, 32'h00002000, 4'hF, 32'h0,        32'h24020005, 32'hAAAA5678};

      reset = 1'b1; preload = 1'b1; mem_wait = 4'd0;
      i_read = 1'b0; i_address = 32'h0; d_read = 1'b0; d_write = 1'b0;
      d_address = 32'h0; d_byteenable = 4'h0; d_writedata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_grant", {30'h0, grant}, 32'h0);
      chk("rst_cmd", {30'h0, read, write}, 32'h0);
      chk("rst_address", address, 32'h0);
      chk("rst_be_wd", {28'h0, byteenable} | writedata, 32'h0);
      chk("rst_stalls", {30'h0, i_waitrequest, d_waitrequest}, 32'h3);
      reset = 1'b0; preload = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         drive(vt[i], cyc);
         chk("latency", 32'(cyc), (vt[i].ir && (vt[i].dr || vt[i].dw)) ? 32'd3 : 32'd1);
      end

      // Three wait states: master command held, requester stalled until the 4th BUSY cycle.
      mem_wait = 4'd3;
      v = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h00001000, 4'hF, 32'h0, 32'h0, 32'hDEADBEEF};
      d_read = 1'b1; d_address = v.da; d_byteenable = v.be;
      push_exp(v);
      stalls = 0; busy = 0;
      while (busy < 20) begin
         @(negedge clk);
         busy++;
         chk("ws_address", address, 32'h00001000);
         chk("ws_cmd", {30'h0, read, write}, 32'h2);
         chk("ws_be", {28'h0, byteenable}, 32'hF);
         if (d_waitrequest) stalls++;
         else break;
      end
      d_read = 1'b0;
      chk("ws_stalls", 32'(stalls), 32'd3);
      chk("ws_busy", 32'(busy), 32'd4);
      @(negedge clk);
      mem_wait = 4'd0;

      // Read and write together: the write wins, lanes pass through, checker counts it.
      v = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h00003000, 4'h3, 32'hCAFEF00D, 32'h0, 32'h0};
      drive(v, cyc);
      chk("conflict_flag", {31'h0, (dut.u_chk.conflict_count != 16'd0)}, 32'h1);
      v = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h00003000, 4'hF, 32'h0, 32'h0, 32'h0000F00D};
      drive(v, cyc);

      // Reset in the middle of a stalled fetch abandons it immediately.
      mem_wait = 4'd5;
      i_read = 1'b1; i_address = 32'hBFC00004;
      repeat (2) @(negedge clk);
      chk("pre_reset_read", {31'h0, read}, 32'h1);
      reset = 1'b1;
      #1;
      chk("busy_rst_cmd", {30'h0, read, write}, 32'h0);
      chk("busy_rst_grant", {30'h0, grant}, 32'h0);
      chk("busy_rst_stalls", {30'h0, i_waitrequest, d_waitrequest}, 32'h3);
      i_read = 1'b0; m_ptr = 1'b1;
      @(negedge clk);
      reset = 1'b0; mem_wait = 4'd0;
      @(negedge clk);
      v = '{1'b1, 32'hBFC00004, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h3C011234, 32'h0};
      drive(v, cyc);
      chk("post_reset_latency", 32'(cyc), 32'd1);

      // Both requesters pending for four transfers.
`ifdef ARB_ROUND_ROBIN_EN
      want_seq = '{GRANT_D, GRANT_I, GRANT_D, GRANT_I};
`else
      want_seq = '{GRANT_D, GRANT_D, GRANT_D, GRANT_D};
`endif
      v = '{1'b1, 32'hBFC00000, 1'b1, 1'b0, 32'h00001000, 4'hF, 32'h0, 32'h24020005, 32'hDEADBEEF};
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         if (pick(1'b1, 1'b1) == GRANT_D) begin
            e = '{GRANT_D, v.da, 1'b1, 1'b0, v.be, 32'h0, v.exp_dr};
            m_ptr = 1'b0;
         end else begin
            e = '{GRANT_I, v.ia, 1'b1, 1'b0, FULL_BE, 32'h0, v.exp_ir};
            m_ptr = 1'b1;
         end
         q.push_back(e);
      end
      i_read = 1'b1; i_address = v.ia; d_read = 1'b1; d_address = v.da; d_byteenable = v.be;
      n = 0; cyc = 0;
      gseq = '{GRANT_NONE, GRANT_NONE, GRANT_NONE, GRANT_NONE};
      while (n < 4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (!i_waitrequest) begin gseq[n] = GRANT_I; n++; end
         if (!d_waitrequest && n < 4) begin gseq[n] = GRANT_D; n++; end
      end
      i_read = 1'b0; d_read = 1'b0;
      chk("cont_count", 32'(n), 32'd4);
      for (int k = 0; k < 4; k++) chk("cont_grant_seq", {30'h0, gseq[k]}, {30'h0, want_seq[k]});
      @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
